// File: rtl/imm_gen_pipe.sv
// imm_gen_pipe: RV32I/RV64I immediate generator, one registered stage.
// Decodes I/S/B/U/J immediates, sign-extends to XLEN, reports the format.
//
// Ports:
//   clk        rising-edge clock
//   reset      synchronous, active-high reset
//   flush      kill the held result and any same-cycle accept
//   in_valid   in_instr valid this cycle
//   in_ready   stage can accept in_instr this cycle
//   in_instr   raw 32-bit instruction word
//   out_valid  out_imm/out_fmt/out_instr valid
//   out_ready  downstream accepts the result this cycle
//   out_imm    sign-extended immediate (XLEN bits)
//   out_fmt    0=NONE 1=I 2=S 3=B 4=U 5=J
//   out_instr  registered copy of the accepted instruction

module imm_gen_pipe #(
    parameter int XLEN  = 64,
    parameter int FMT_W = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_instr,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  out_imm,
    output logic [FMT_W-1:0] out_fmt,
    output logic [31:0]      out_instr
);

    localparam logic [FMT_W-1:0] FMT_NONE = FMT_W'(0);
    localparam logic [FMT_W-1:0] FMT_I    = FMT_W'(1);
    localparam logic [FMT_W-1:0] FMT_S    = FMT_W'(2);
    localparam logic [FMT_W-1:0] FMT_B    = FMT_W'(3);
    localparam logic [FMT_W-1:0] FMT_U    = FMT_W'(4);
    localparam logic [FMT_W-1:0] FMT_J    = FMT_W'(5);

    logic [6:0]       opc;
    logic             is_i;
    logic             is_s;
    logic             is_b;
    logic             is_u;
    logic             is_j;
    logic [FMT_W-1:0] fmt_d;
    logic [31:0]      imm32;
    logic [XLEN-1:0]  imm_d;
    logic             accept;

    assign opc = in_instr[6:0];

    // loads, op-imm, op-imm-32, jalr, fence, system
    assign is_i = (opc == 7'b0000011) || (opc == 7'b0010011) ||
                  (opc == 7'b0011011) || (opc == 7'b1100111) ||
                  (opc == 7'b0001111) || (opc == 7'b1110011);
    assign is_s = (opc == 7'b0100011);
    assign is_b = (opc == 7'b1100011);
    assign is_u = (opc == 7'b0110111) || (opc == 7'b0010111);
    assign is_j = (opc == 7'b1101111);

    // Build the immediate at 32 bits first; every format is then
    // widened the same way, so no bit of out_imm is left unassigned.
    always_comb begin
        fmt_d = FMT_NONE;
        imm32 = '0;
        unique case (1'b1)
            is_i: begin
                fmt_d = FMT_I;
                imm32 = {{20{in_instr[31]}}, in_instr[31:20]};
            end
            is_s: begin
                fmt_d = FMT_S;
                imm32 = {{20{in_instr[31]}}, in_instr[31:25],
                         in_instr[11:7]};
            end
            is_b: begin
                fmt_d = FMT_B;
                imm32 = {{20{in_instr[31]}}, in_instr[7],
                         in_instr[30:25], in_instr[11:8], 1'b0};
            end
            is_u: begin
                fmt_d = FMT_U;
                imm32 = {in_instr[31:12], 12'b0};
            end
            is_j: begin
                fmt_d = FMT_J;
                imm32 = {{12{in_instr[31]}}, in_instr[19:12],
                         in_instr[20], in_instr[30:21], 1'b0};
            end
            default: begin
                fmt_d = FMT_NONE;
                imm32 = '0;
            end
        endcase
    end

    // imm32[31] always equals in_instr[31] (or 0 for NONE), so
    // replicating it sign-extends from the instruction's top bit.
    if (XLEN > 32) begin : g_wide
        assign imm_d = {{(XLEN-32){imm32[31]}}, imm32};
    end else begin : g_narrow
        assign imm_d = imm32[XLEN-1:0];
    end

    assign in_ready = !out_valid || out_ready;
    assign accept   = in_valid && in_ready;

    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid <= 1'b0;
            out_imm   <= '0;
            out_fmt   <= '0;
            out_instr <= '0;
        end else begin
            if (flush) begin
                out_valid <= 1'b0;
            end else if (accept) begin
                out_valid <= 1'b1;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
            // a flushed accept is dropped; data regs keep stale values
            if (accept && !flush) begin
                out_imm   <= imm_d;
                out_fmt   <= fmt_d;
                out_instr <= in_instr;
            end
        end
    end

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Testbench for imm_gen_pipe (XLEN=64): directed vectors, scoreboard
// queue filled by the driver and drained by a negedge monitor.

module tb_imm_gen_pipe;

    localparam int NV = 16;

    typedef struct {
        logic [63:0] imm;
        logic [2:0]  fmt;
        logic [31:0] instr;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] in_instr = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [63:0] out_imm;
    logic [2:0]  out_fmt;
    logic [31:0] out_instr;

    imm_gen_pipe #(.XLEN(64), .FMT_W(3)) dut (
        .clk       (clk),
        .reset     (reset),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_instr  (in_instr),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_imm   (out_imm),
        .out_fmt   (out_fmt),
        .out_instr (out_instr)
    );

    always #5 clk = ~clk;

    // hand-decoded instruction table
    logic [31:0] vi [NV] = '{
        32'hFFF00093, 32'h0020A423, 32'hFE000EE3, 32'h800002B7,
        32'h0010006F, 32'h12345017, 32'h00812083, 32'h7FF08067,
        32'hFE112E23, 32'h00000073, 32'h0FF0000F, 32'h8001009B,
        32'h002081B3, 32'hFF9FF06F, 32'h00000863, 32'h0000007F
    };
    logic [2:0] vf [NV] = '{
        3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd4, 3'd1, 3'd1,
        3'd2, 3'd1, 3'd1, 3'd1, 3'd0, 3'd5, 3'd3, 3'd0
    };
    logic [63:0] vm [NV] = '{
        64'hFFFF_FFFF_FFFF_FFFF, 64'h8,
        64'hFFFF_FFFF_FFFF_FFFC, 64'hFFFF_FFFF_8000_0000,
        64'h800,                 64'h1234_5000,
        64'h8,                   64'h7FF,
        64'hFFFF_FFFF_FFFF_FFFC, 64'h0,
        64'hFF,                  64'hFFFF_FFFF_FFFF_F800,
        64'h0,                   64'hFFFF_FFFF_FFFF_FFF8,
        64'h10,                  64'h0
    };

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;
    logic mv = 1'b0;
    logic mv_nxt = 1'b0;
    logic run = 1'b0;

    task automatic chk(input string nm, input logic [63:0] got,
                       input logic [63:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %h want %h", nm, got, want);
        end
    endtask

    // one cycle of stimulus; updates the handshake model
    task automatic step(input logic v, input int idx, input logic ordy,
                        input logic fl, input logic rst,
                        output logic acc);
        exp_t e;
        @(posedge clk);
        #1;
        mv        = mv_nxt;
        in_valid  = v;
        in_instr  = vi[idx];
        out_ready = ordy;
        flush     = fl;
        reset     = rst;
        acc = v && (!mv || ordy);
        if (!rst && !fl && acc) begin
            e.imm   = vm[idx];
            e.fmt   = vf[idx];
            e.instr = vi[idx];
            q.push_back(e);
        end
        if (rst || fl)    mv_nxt = 1'b0;
        else if (acc)     mv_nxt = 1'b1;
        else if (ordy)    mv_nxt = 1'b0;
        else              mv_nxt = mv;
    endtask

    // monitor
    logic        prev_rst = 1'b1;
    logic        prev_hold = 1'b0;
    logic [63:0] h_imm;
    logic [2:0]  h_fmt;
    logic [31:0] h_instr;

    always @(negedge clk) begin
        exp_t e;
        if (run) begin
            chk("out_valid", 64'(out_valid), 64'(mv));
            chk("in_ready", 64'(in_ready), 64'(!mv || out_ready));
            if (prev_rst) begin
                chk("rst_imm", out_imm, 64'h0);
                chk("rst_fmt", 64'(out_fmt), 64'h0);
                chk("rst_instr", 64'(out_instr), 64'h0);
            end
            if (prev_hold) begin
                chk("hold_imm", out_imm, h_imm);
                chk("hold_fmt", 64'(out_fmt), 64'(h_fmt));
                chk("hold_instr", 64'(out_instr), 64'(h_instr));
            end
            if (reset) begin
                q.delete();
            end else if (mv && out_ready) begin
                if (q.size() == 0) begin
                    chk("sb_empty", 64'(q.size()), 64'h1);
                end else begin
                    e = q.pop_front();
                    chk("imm", out_imm, e.imm);
                    chk("fmt", 64'(out_fmt), 64'(e.fmt));
                    chk("instr", 64'(out_instr), 64'(e.instr));
                end
            end else if (mv && flush) begin
                if (q.size() != 0) void'(q.pop_front());
            end
            prev_rst  = reset;
            prev_hold = mv && !out_ready && !flush && !reset;
            h_imm     = out_imm;
            h_fmt     = out_fmt;
            h_instr   = out_instr;
        end
    end

    initial begin
        logic a;
        int   idx;
        repeat (2) @(posedge clk);
        #1;
        run = 1'b1;
        step(0, 0, 1, 0, 1, a);
        // stream every vector with continuous out_ready
        for (int i = 0; i < NV; i++) step(1, i, 1, 0, 0, a);
        step(0, 0, 1, 0, 0, a);
        // back-pressure: 3 stalled cycles with in_valid high
        step(1, 0, 1, 0, 0, a);
        for (int i = 0; i < 3; i++) step(1, 3, 0, 0, 0, a);
        step(1, 3, 1, 0, 0, a);
        step(0, 0, 1, 0, 0, a);
        // flush with an accept in the same cycle
        step(1, 4, 1, 1, 0, a);
        step(0, 0, 1, 0, 0, a);
        // flush while holding a stalled result
        step(1, 2, 0, 0, 0, a);
        step(0, 0, 0, 1, 0, a);
        step(0, 0, 1, 0, 0, a);
        // reset mid-stream with out_valid=1
        step(1, 13, 1, 0, 0, a);
        step(1, 11, 0, 0, 1, a);
        step(1, 8, 1, 0, 0, a);
        // random handshake over the table
        idx = 0;
        for (int i = 0; i < 400; i++) begin
            step(1'($urandom_range(0, 3) != 0), idx,
                 1'($urandom_range(0, 2) != 0),
                 1'($urandom_range(0, 19) == 0),
                 1'($urandom_range(0, 99) == 0), a);
            if (a) idx = (idx + 1) % NV;
        end
        for (int i = 0; i < 4; i++) step(0, 0, 1, 0, 0, a);
        @(negedge clk);
        #1;
        chk("drain", 64'(q.size()), 64'h0);
        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
